// File: rtl/seis_bits_pkg.sv
// Shared definitions for the 6-bit dual-interface bus: idle patterns, decoder
// FSM states and the decoded-word layout.
package seis_bits_pkg;

  // A group that carries no function word sits at this pattern.
  localparam logic [2:0] IDLE_GRP = 3'b110;
  localparam logic [5:0] BUS_IDLE = {IDLE_GRP, IDLE_GRP};

  // Function word reported when both groups are idle: {a,b,c} = {0,1,1}.
  localparam logic [2:0] AMB_FUNC = 3'b011;

  typedef enum logic [0:0] {
    SETTLE,
    HOLD
  } state_e;

  typedef struct packed {
    logic [2:0] func;  // {a,b,c}, a in bit 2
    logic       sel;   // recovered d
    logic       amb;   // both groups idle
  } word_t;

  function automatic logic grp_idle(input logic [2:0] grp);
    return grp == IDLE_GRP;
  endfunction

endpackage

// File: rtl/seis_bits_dec1_if.sv
// Bus-side and consumer-side signals of the 6-bit receive decoder.
// master: drives the bus and the consumer ready; slave: the decoder itself.
interface seis_bits_dec1_if;

  logic [5:0] seis_bits_in;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] func_out;
  logic       sel_out;
  logic       amb_out;
  logic       err_pulse;
  logic       ovr_pulse;

  modport master (
    output seis_bits_in,
    output out_ready,
    input  out_valid,
    input  func_out,
    input  sel_out,
    input  amb_out,
    input  err_pulse,
    input  ovr_pulse
  );

  modport slave (
    input  seis_bits_in,
    input  out_ready,
    output out_valid,
    output func_out,
    output sel_out,
    output amb_out,
    output err_pulse,
    output ovr_pulse
  );

endinterface

// File: rtl/seis_bits_sync.sv
// Two-flop synchroniser with a configurable reset value, for a bus that is
// asynchronous to clk. Bits are synchronised independently; the debounce
// downstream absorbs any skew between them.
module seis_bits_sync #(
  parameter int unsigned          WIDTH   = 6,
  parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= RST_VAL;
      sync2 <= RST_VAL;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  assign dout = sync2;

endmodule

// File: rtl/seis_bits_dec1.sv
// Receive-side decoder for the 6-bit dual-interface bus. Synchronises the
// bus, waits until it has been stable for STABLE_CYC equal samples, decodes
// which 3-bit group carries the function word and offers the result on a
// valid/ready output. Illegal settled patterns and overwritten pending words
// are flagged with single-cycle pulses.
module seis_bits_dec1
  import seis_bits_pkg::*;
#(
  parameter int unsigned STABLE_CYC = 4
) (
  input logic             clk,
  input logic             rst_n,
  seis_bits_dec1_if.slave bus
);

  localparam int unsigned      CNT_W    = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);

  logic [5:0]       sync2;
  logic [5:0]       prev;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  word_t            word_q;
  logic             valid_q;
  logic             err_q;
  logic             ovr_q;

  logic             changed;
  logic             decode;
  logic             legal;
  logic             load;
  word_t            dec_word;

  // Both-idle keeps the previous sel because d cannot be recovered from the bus.
  function automatic word_t decode_bus(input logic [5:0] s, input logic sel_prev);
    word_t w;
    w.func = AMB_FUNC;
    w.sel  = sel_prev;
    w.amb  = 1'b1;
    if (grp_idle(s[5:3]) && !grp_idle(s[2:0])) begin
      w.func = {s[0], s[1], s[2]};
      w.sel  = 1'b0;
      w.amb  = 1'b0;
    end else if (grp_idle(s[2:0]) && !grp_idle(s[5:3])) begin
      w.func = {s[3], s[4], s[5]};
      w.sel  = 1'b1;
      w.amb  = 1'b0;
    end
    return w;
  endfunction

  seis_bits_sync #(
    .WIDTH   (6),
    .RST_VAL (BUS_IDLE)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.seis_bits_in),
    .dout  (sync2)
  );

  // One-cycle-delayed copy of the synchronised bus for change detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= BUS_IDLE;
    end else begin
      prev <= sync2;
    end
  end

  // Settled-value classification and decode strobe.
  always_comb begin
    changed  = (sync2 != prev);
    decode   = (state_q == SETTLE) && !changed && (cnt_q == CNT_LAST);
    legal    = grp_idle(sync2[5:3]) || grp_idle(sync2[2:0]);
    load     = decode && legal;
    dec_word = decode_bus(sync2, word_q.sel);
  end

  // Debounce FSM with registered word, valid and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SETTLE;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      ovr_q <= 1'b0;

      case (state_q)
        SETTLE: begin
          if (changed) begin
            cnt_q <= '0;
          end else if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            state_q <= HOLD;
            err_q   <= !legal;
          end
        end
        HOLD: begin
          // A held value is emitted once; only a new change re-arms the count.
          if (changed) begin
            cnt_q   <= '0;
            state_q <= SETTLE;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= SETTLE;
        end
      endcase

      if (load) begin
        word_q  <= dec_word;
        valid_q <= 1'b1;
        ovr_q   <= valid_q && !bus.out_ready;
      end else if (valid_q && bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.func_out  = word_q.func;
  assign bus.sel_out   = word_q.sel;
  assign bus.amb_out   = word_q.amb;
  assign bus.err_pulse = err_q;
  assign bus.ovr_pulse = ovr_q;

endmodule

// File: tb/tb_seis_bits_dec1.sv
// Directed bench for seis_bits_dec1 with default STABLE_CYC = 4.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after the counted rising edge.
module tb_seis_bits_dec1;

  localparam logic [5:0] BUS_A  = 6'b110_101;  // H idle, L=101 -> func 101, sel 0
  localparam logic [5:0] BUS_B  = 6'b011_110;  // L idle, H=011 -> func 110, sel 1
  localparam logic [5:0] BUS_ID = 6'b110_110;  // both idle
  localparam logic [5:0] BUS_BAD = 6'b000_000; // neither idle

  logic clk;
  logic rst_n;
  int   nvec;
  int   nerr;
  logic seen;

  seis_bits_dec1_if bus ();

  seis_bits_dec1 #(
    .STABLE_CYC (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // {valid, func, sel, amb}
  function automatic logic [5:0] word_obs();
    return {bus.out_valid, bus.func_out, bus.sel_out, bus.amb_out};
  endfunction

  initial begin
    nvec = 0;
    nerr = 0;
    rst_n = 1'b0;
    bus.seis_bits_in = BUS_ID;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_word", {26'd0, word_obs()}, 32'h0);
    check("reset_pulses", {30'd0, bus.err_pulse, bus.ovr_pulse}, 32'h0);

    // Idle bus straight out of reset is emitted after four equal samples.
    rst_n = 1'b1;
    tick(3);
    check("idle_after_rst_wait", {31'd0, bus.out_valid}, 32'd0);
    tick(1);
    check("idle_after_rst_word", {26'd0, word_obs()}, {26'd0, 1'b1, 3'b011, 1'b0, 1'b1});
    tick(1);
    check("idle_after_rst_taken", {31'd0, bus.out_valid}, 32'd0);

    // Low group active.
    bus.seis_bits_in = BUS_A;
    tick(6);
    check("a_edge6", {31'd0, bus.out_valid}, 32'd0);
    tick(1);
    check("a_word", {26'd0, word_obs()}, {26'd0, 1'b1, 3'b101, 1'b0, 1'b0});
    tick(1);
    check("a_one_cycle", {31'd0, bus.out_valid}, 32'd0);
    seen = 1'b0;
    repeat (3) begin
      tick(1);
      seen |= bus.out_valid;
    end
    check("a_no_reemit", {31'd0, seen}, 32'd0);

    // High group active.
    bus.seis_bits_in = BUS_B;
    tick(7);
    check("b_word", {26'd0, word_obs()}, {26'd0, 1'b1, 3'b110, 1'b1, 1'b0});
    tick(1);
    check("b_taken", {31'd0, bus.out_valid}, 32'd0);

    // Both idle after a sel=1 word keeps sel.
    bus.seis_bits_in = BUS_ID;
    tick(7);
    check("amb_word", {26'd0, word_obs()}, {26'd0, 1'b1, 3'b011, 1'b1, 1'b1});
    tick(1);

    // Neither group idle: error pulse only, register untouched.
    bus.seis_bits_in = BUS_BAD;
    tick(6);
    check("err_before", {31'd0, bus.err_pulse}, 32'd0);
    tick(1);
    check("err_pulse", {31'd0, bus.err_pulse}, 32'd1);
    check("err_word_kept", {26'd0, word_obs()}, {26'd0, 1'b0, 3'b011, 1'b1, 1'b1});
    tick(1);
    check("err_one_cycle", {31'd0, bus.err_pulse}, 32'd0);

    // Toggling every three cycles never settles; final value emitted 7 edges on.
    seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.seis_bits_in = (i % 2 == 0) ? BUS_A : BUS_B;
      repeat (3) begin
        tick(1);
        seen |= bus.out_valid | bus.err_pulse;
      end
    end
    check("toggle_quiet", {31'd0, seen}, 32'd0);
    tick(3);
    check("toggle_edge6", {31'd0, bus.out_valid}, 32'd0);
    tick(1);
    check("toggle_final", {26'd0, word_obs()}, {26'd0, 1'b1, 3'b101, 1'b0, 1'b0});
    tick(1);
    check("toggle_single", {31'd0, bus.out_valid}, 32'd0);

    // Overrun: B pending unaccepted, A replaces it.
    bus.out_ready = 1'b0;
    bus.seis_bits_in = BUS_B;
    tick(7);
    check("ovr_first", {26'd0, word_obs()}, {26'd0, 1'b1, 3'b110, 1'b1, 1'b0});
    check("ovr_first_nopulse", {31'd0, bus.ovr_pulse}, 32'd0);
    bus.seis_bits_in = BUS_A;
    tick(6);
    check("ovr_pending_held", {26'd0, word_obs()}, {26'd0, 1'b1, 3'b110, 1'b1, 1'b0});
    tick(1);
    check("ovr_pulse", {31'd0, bus.ovr_pulse}, 32'd1);
    check("ovr_new_word", {26'd0, word_obs()}, {26'd0, 1'b1, 3'b101, 1'b0, 1'b0});
    tick(1);
    check("ovr_one_cycle", {31'd0, bus.ovr_pulse}, 32'd0);
    bus.out_ready = 1'b1;
    tick(1);
    check("ovr_accept_once", {26'd0, word_obs()}, {26'd0, 1'b0, 3'b101, 1'b0, 1'b0});

    // Handshake and load on the same edge: new word stays valid, no overrun.
    bus.out_ready = 1'b0;
    bus.seis_bits_in = BUS_B;
    tick(7);
    check("hs_pending", {31'd0, bus.out_valid}, 32'd1);
    bus.seis_bits_in = BUS_A;
    tick(6);
    bus.out_ready = 1'b1;
    tick(1);
    check("hs_load_word", {26'd0, word_obs()}, {26'd0, 1'b1, 3'b101, 1'b0, 1'b0});
    check("hs_load_noovr", {31'd0, bus.ovr_pulse}, 32'd0);
    tick(1);
    check("hs_load_taken", {31'd0, bus.out_valid}, 32'd0);

    // Asynchronous reset in the middle of a settle.
    bus.seis_bits_in = BUS_B;
    tick(3);
    rst_n = 1'b0;
    #1;
    check("async_rst_word", {26'd0, word_obs()}, 32'h0);
    check("async_rst_pulses", {30'd0, bus.err_pulse, bus.ovr_pulse}, 32'h0);
    tick(2);
    check("rst_held_word", {26'd0, word_obs()}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
